seg7_hc595_driver: RTL and testbench

SEG7_HC595_DRIVER -- requirements
Module: seg7_hc595_driver

---
 rtl/seg7_hc595_driver.sv | 199 +++++++++++++++++++
 tb/tb_seg7_hc595_driver.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_hc595_driver.sv
// Four-digit 7-segment scanner feeding two cascaded 74HC595s: each digit is sent
// as one 16-bit word {dp,g..a active-low, one-hot digit select}, then latched and held.
module seg7_hc595_driver #(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dots,
  input  logic [3:0]  i_en_mask,
  output logic        o_stcp,
  output logic        o_shcp,
  output logic        o_ds,
  output logic        o_oe
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  // Active-high {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'h0: seg_lut = 7'h3F;
      4'h1: seg_lut = 7'h06;
      4'h2: seg_lut = 7'h5B;
      4'h3: seg_lut = 7'h4F;
      4'h4: seg_lut = 7'h66;
      4'h5: seg_lut = 7'h6D;
      4'h6: seg_lut = 7'h7D;
      4'h7: seg_lut = 7'h07;
      4'h8: seg_lut = 7'h7F;
      4'h9: seg_lut = 7'h6F;
      4'hA: seg_lut = 7'h77;
      4'hB: seg_lut = 7'h7C;
      4'hC: seg_lut = 7'h39;
      4'hD: seg_lut = 7'h5E;
      4'hE: seg_lut = 7'h79;
      default: seg_lut = 7'h71;
    endcase
  endfunction

  function automatic logic [15:0] make_word(input logic [15:0] data, input logic [3:0] dots,
                                            input logic [3:0] mask, input logic [1:0] idx);
    logic [6:0] seg;
    logic [7:0] hi;
    seg = seg_lut(data[{idx, 2'b00} +: 4]);
    hi  = mask[idx] ? ~{dots[idx], seg} : 8'hFF;
    return {hi, 4'b0000, 4'b0001 << idx};
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   frame_data_q, frame_data_d;
  logic [3:0]    frame_dots_q, frame_dots_d;
  logic [3:0]    frame_mask_q, frame_mask_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          stcp_q, stcp_d;
  logic          shcp_q, shcp_d;
  logic          ds_q, ds_d;
  logic          oe_q, oe_d;
  logic          latched_q, latched_d;
  logic [15:0]   word;

  // Counters describe the position about to be emitted; each edge registers the
  // outputs for that position and advances, so the first bit appears one edge after reset.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    digit_d      = digit_q;
    bit_d        = bit_q;
    div_d        = div_q;
    hold_d       = hold_q;
    frame_data_d = frame_data_q;
    frame_dots_d = frame_dots_q;
    frame_mask_d = frame_mask_q;
    shreg_d      = shreg_q;
    stcp_d       = 1'b0;
    shcp_d       = 1'b0;
    ds_d         = ds_q;
    word         = '0;

    case (state_q)
      S_SHIFT: begin
        shcp_d = (div_q >= DIV_HALF);
        if (div_q == '0) begin
          if (bit_q == '0) begin
            if (digit_q == 2'd0) begin
              frame_data_d = i_data;
              frame_dots_d = i_dots;
              frame_mask_d = i_en_mask;
              word         = make_word(i_data, i_dots, i_en_mask, 2'd0);
            end else begin
              word = make_word(frame_data_q, frame_dots_q, frame_mask_q, digit_q);
            end
            ds_d    = word[15];
            shreg_d = {word[14:0], 1'b0};
          end else begin
            ds_d    = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = S_LATCH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_LATCH: begin
        stcp_d = (div_q < DIV_HALF);
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (HOLD_CYCLES == 0) begin
            state_d = S_SHIFT;
            digit_d = digit_q + 2'd1;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_SHIFT;
          digit_d = digit_q + 2'd1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = S_SHIFT;
    endcase

    // Display stays dark until a complete word has reached the storage register.
    latched_d = latched_q | (stcp_q & ~stcp_d);
    oe_d      = ~latched_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame register is reset too, so nothing stale can ever be shifted out.
      state_q      <= S_SHIFT;
      digit_q      <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      hold_q       <= '0;
      frame_data_q <= '0;
      frame_dots_q <= '0;
      frame_mask_q <= '0;
      shreg_q      <= '0;
      stcp_q       <= 1'b0;
      shcp_q       <= 1'b0;
      ds_q         <= 1'b0;
      oe_q         <= 1'b1;
      latched_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      digit_q      <= digit_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      hold_q       <= hold_d;
      frame_data_q <= frame_data_d;
      frame_dots_q <= frame_dots_d;
      frame_mask_q <= frame_mask_d;
      shreg_q      <= shreg_d;
      stcp_q       <= stcp_d;
      shcp_q       <= shcp_d;
      ds_q         <= ds_d;
      oe_q         <= oe_d;
      latched_q    <= latched_d;
    end
  end

  assign o_stcp = stcp_q;
  assign o_shcp = shcp_q;
  assign o_ds   = ds_q;
  assign o_oe   = oe_q;

endmodule

// File: tb/tb_seg7_hc595_driver.sv
// Bench for seg7_hc595_driver: serial monitors rebuild each latched word and a
// table-driven reference predicts it from the inputs captured at each frame start.
module tb_seg7_hc595_driver;

  localparam int CD_A = 2, HC_A = 0, CD_B = 1, HC_B = 5;
  localparam int PER_A = 34 * CD_A + HC_A;
  localparam int PER_B = 34 * CD_B + HC_B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] i_data;
  logic [3:0]  i_dots, i_en_mask;
  logic        stcp_a, shcp_a, ds_a, oe_a;
  logic        stcp_b, shcp_b, ds_b, oe_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] cur_d;
  logic [3:0]  cur_dots, cur_mask;
  logic [15:0] got [7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_hc595_driver #(.CLK_DIV(CD_A), .HOLD_CYCLES(HC_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_dots(i_dots), .i_en_mask(i_en_mask),
    .o_stcp(stcp_a), .o_shcp(shcp_a), .o_ds(ds_a), .o_oe(oe_a));

  seg7_hc595_driver #(.CLK_DIV(CD_B), .HOLD_CYCLES(HC_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_dots(i_dots), .i_en_mask(i_en_mask),
    .o_stcp(stcp_b), .o_shcp(shcp_b), .o_ds(ds_b), .o_oe(oe_b));

  // Reference: what a display digit should receive, straight from the segment rules.
  function automatic logic [15:0] model_word(input logic [15:0] d, input logic [3:0] dots,
                                             input logic [3:0] m, input int n);
    logic [7:0] tbl [16];
    logic [7:0] seg, hi, lo;
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    seg = tbl[(d >> (4 * n)) & 16'hF];
    hi  = m[n] ? ~{dots[n], seg[6:0]} : 8'hFF;
    lo  = 8'h01 << n;
    return {hi, lo};
  endfunction

  // ---------------- serial monitors (sampled on falling clk) ----------------
  logic [15:0] sh_a = '0, sh_b = '0;
  int nb_a = 0, nb_b = 0, hi_a = 0, hi_b = 0, shw_a = 0, shw_b = 0;
  int ff_a = -1, oef_a = -1, bad_shcp_a = 0, ds_err_a = 0, overlap_a = 0, oe_rise_a = 0;
  int bad_shcp_b = 0, ds_err_b = 0, overlap_b = 0;
  logic stcp_pa = 0, shcp_pa = 0, ds_pa = 0, oe_pa = 1;
  logic stcp_pb = 0, shcp_pb = 0, ds_pb = 0;
  logic [15:0] qw_a [$], qw_b [$];
  int qb_a [$], qc_a [$], qwid_a [$], qb_b [$], qc_b [$], qwid_b [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sh_a <= '0; nb_a <= 0; hi_a <= 0; shw_a <= 0; ff_a <= -1; oef_a <= -1;
      stcp_pa <= 1'b0; shcp_pa <= 1'b0; ds_pa <= 1'b0; oe_pa <= 1'b1;
    end else begin
      stcp_pa <= stcp_a; shcp_pa <= shcp_a; ds_pa <= ds_a; oe_pa <= oe_a;
      if (shcp_a && !shcp_pa) begin sh_a <= {sh_a[14:0], ds_a}; nb_a <= nb_a + 1; end
      shw_a <= shcp_a ? shw_a + 1 : 0;
      if (!shcp_a && shcp_pa && shw_a != CD_A) bad_shcp_a <= bad_shcp_a + 1;
      if (shcp_a && ds_a !== ds_pa) ds_err_a <= ds_err_a + 1;
      if (stcp_a && shcp_a) overlap_a <= overlap_a + 1;
      if (stcp_a && !stcp_pa) begin
        qw_a.push_back(sh_a); qb_a.push_back(nb_a); qc_a.push_back(cyc); nb_a <= 0;
      end
      hi_a <= stcp_a ? hi_a + 1 : 0;
      if (!stcp_a && stcp_pa) begin
        qwid_a.push_back(hi_a);
        if (ff_a < 0) ff_a <= cyc;
      end
      if (!oe_a && oe_pa && oef_a < 0) oef_a <= cyc;
      if (oe_a && !oe_pa) oe_rise_a <= oe_rise_a + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sh_b <= '0; nb_b <= 0; hi_b <= 0; shw_b <= 0;
      stcp_pb <= 1'b0; shcp_pb <= 1'b0; ds_pb <= 1'b0;
    end else begin
      stcp_pb <= stcp_b; shcp_pb <= shcp_b; ds_pb <= ds_b;
      if (shcp_b && !shcp_pb) begin sh_b <= {sh_b[14:0], ds_b}; nb_b <= nb_b + 1; end
      shw_b <= shcp_b ? shw_b + 1 : 0;
      if (!shcp_b && shcp_pb && shw_b != CD_B) bad_shcp_b <= bad_shcp_b + 1;
      if (shcp_b && ds_b !== ds_pb) ds_err_b <= ds_err_b + 1;
      if (stcp_b && shcp_b) overlap_b <= overlap_b + 1;
      if (stcp_b && !stcp_pb) begin
        qw_b.push_back(sh_b); qb_b.push_back(nb_b); qc_b.push_back(cyc); nb_b <= 0;
      end
      hi_b <= stcp_b ? hi_b + 1 : 0;
      if (!stcp_b && stcp_pb) qwid_b.push_back(hi_b);
    end
  end

  // ---------------- bounded word fetch ----------------
  task automatic pop_a(output logic [15:0] w, output int nb, output int c);
    int n = 0;
    while (qw_a.size() == 0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (qw_a.size() == 0) begin
      errors++;
      $display("FAIL word_timeout_a: got no latch in %0d cycles, required one", n);
      w = 'x; nb = -1; c = -1;
    end else begin
      w = qw_a.pop_front(); nb = qb_a.pop_front(); c = qc_a.pop_front();
    end
  endtask

  task automatic pop_b(output logic [15:0] w, output int nb, output int c);
    int n = 0;
    while (qw_b.size() == 0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (qw_b.size() == 0) begin
      errors++;
      $display("FAIL word_timeout_b: got no latch in %0d cycles, required one", n);
      w = 'x; nb = -1; c = -1;
    end else begin
      w = qw_b.pop_front(); nb = qb_b.pop_front(); c = qc_b.pop_front();
    end
  endtask

  task automatic flush_a();
    qw_a.delete(); qb_a.delete(); qc_a.delete(); qwid_a.delete();
  endtask

  // Change inputs while digit 1 is shifting, then check 7 words: digits 1..3 from
  // the old frame, then digit 0..3 from the new one.
  task automatic run_change(input logic [15:0] nd, input logic [3:0] ndots,
                            input logic [3:0] nmask, input string tag);
    logic [15:0] w, expw;
    int nb, c, n, guard;
    flush_a();
    guard = 0;
    do begin pop_a(w, nb, c); guard++; end while (w[7:0] !== 8'h01 && guard < 8);
    repeat (10) @(negedge clk);
    i_data = nd; i_dots = ndots; i_en_mask = nmask;
    for (int k = 0; k < 7; k++) begin
      n = (k + 1) % 4;
      pop_a(w, nb, c);
      expw = (k < 3) ? model_word(cur_d, cur_dots, cur_mask, n) : model_word(nd, ndots, nmask, n);
      checks++;
      if (w !== expw) begin
        errors++;
        $display("FAIL %s_word%0d_digit%0d: got %h required %h", tag, k, n, w, expw);
      end
      checks++;
      if (nb !== 16) begin
        errors++;
        $display("FAIL %s_shcp_edges%0d: got %0d required 16", tag, k, nb);
      end
      got[k] = w;
    end
    cur_d = nd; cur_dots = ndots; cur_mask = nmask;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stcp_a !== 1'b0) begin errors++; $display("FAIL reset_stcp: got %b required 0", stcp_a); end
    checks++; if (shcp_a !== 1'b0) begin errors++; $display("FAIL reset_shcp: got %b required 0", shcp_a); end
    checks++; if (ds_a !== 1'b0) begin errors++; $display("FAIL reset_ds: got %b required 0", ds_a); end
    checks++; if (oe_a !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b required 1", oe_a); end
    repeat (3) @(negedge clk);
    checks++;
    if ({stcp_a, shcp_a, ds_a, oe_a} !== 4'b0001) begin
      errors++; $display("FAIL reset_held: got %b required 0001", {stcp_a, shcp_a, ds_a, oe_a});
    end
  endtask

  task automatic test_first_bit();
    logic [15:0] w0;
    w0 = model_word(i_data, i_dots, i_en_mask, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ds_a !== w0[15]) begin errors++; $display("FAIL first_bit: got %b required %b", ds_a, w0[15]); end
    checks++; if (shcp_a !== 1'b0) begin errors++; $display("FAIL first_bit_shcp: got %b required 0", shcp_a); end
    checks++; if (oe_a !== 1'b1) begin errors++; $display("FAIL first_bit_oe: got %b required 1", oe_a); end
  endtask

  task automatic test_fixed_1234();
    logic [15:0] exp_c [4];
    logic [15:0] w, expw;
    int nb, c, prev_c, wid;
    exp_c = '{16'h9901, 16'hB002, 16'hA404, 16'hF908};
    prev_c = -1;
    for (int k = 0; k < 8; k++) begin
      pop_a(w, nb, c);
      expw = model_word(cur_d, cur_dots, cur_mask, k % 4);
      checks++;
      if (w !== exp_c[k % 4] || w !== expw) begin
        errors++; $display("FAIL fixed_word%0d: got %h required %h", k, w, exp_c[k % 4]);
      end
      checks++;
      if (nb !== 16) begin errors++; $display("FAIL fixed_edges%0d: got %0d required 16", k, nb); end
      if (k > 0) begin
        checks++;
        if (c - prev_c !== PER_A) begin
          errors++; $display("FAIL fixed_period%0d: got %0d required %0d", k, c - prev_c, PER_A);
        end
      end
      prev_c = c;
    end
    repeat (2 * CD_A + 2) @(negedge clk);
    checks++;
    if (qwid_a.size() == 0) begin
      errors++; $display("FAIL stcp_width: got no pulse required %0d", CD_A);
    end else begin
      wid = qwid_a.pop_front();
      if (wid !== CD_A) begin errors++; $display("FAIL stcp_width: got %0d required %0d", wid, CD_A); end
    end
    checks++;
    if (ff_a < 0 || oef_a !== ff_a + 1) begin
      errors++; $display("FAIL oe_release: got oe fall at %0d required %0d", oef_a, ff_a + 1);
    end
  endtask

  task automatic test_mask_dots();
    run_change(16'h1234, 4'b0001, 4'b1110, "mask");
    checks++; if (got[3] !== 16'hFF01) begin errors++; $display("FAIL mask_digit0: got %h required ff01", got[3]); end
    checks++; if (got[4] !== 16'hB002) begin errors++; $display("FAIL mask_digit1: got %h required b002", got[4]); end
    run_change(16'h1234, 4'b0010, 4'hF, "dots");
    checks++; if (got[3] !== 16'h9901) begin errors++; $display("FAIL dots_digit0: got %h required 9901", got[3]); end
    checks++; if (got[4] !== 16'h3002) begin errors++; $display("FAIL dots_digit1: got %h required 3002", got[4]); end
  endtask

  task automatic test_midshift_change();
    run_change(16'h1234, 4'h0, 4'hF, "restore");
    run_change(16'h5678, 4'h0, 4'hF, "midshift");
    checks++; if (got[0] !== 16'hB002) begin errors++; $display("FAIL midshift_old1: got %h required b002", got[0]); end
    checks++; if (got[2] !== 16'hF908) begin errors++; $display("FAIL midshift_old3: got %h required f908", got[2]); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++)
      run_change(16'($urandom), 4'($urandom), 4'($urandom), $sformatf("rand%0d", r));
  endtask

  task automatic test_reset_midshift();
    logic [15:0] w, expw;
    int nb, c, guard;
    flush_a();
    guard = 0;
    do begin pop_a(w, nb, c); guard++; end while (w[7:0] !== 8'h02 && guard < 8);
    repeat (3 + 7 * 2 * CD_A + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stcp_a, shcp_a, ds_a, oe_a} !== 4'b0001) begin
      errors++; $display("FAIL midreset_async: got %b required 0001", {stcp_a, shcp_a, ds_a, oe_a});
    end
    repeat (3) @(negedge clk);
    flush_a();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (oe_a !== 1'b1) begin errors++; $display("FAIL midreset_oe: got %b required 1", oe_a); end
    pop_a(w, nb, c);
    expw = model_word(cur_d, cur_dots, cur_mask, 0);
    checks++;
    if (w !== expw) begin errors++; $display("FAIL midreset_word: got %h required %h", w, expw); end
    checks++;
    if (nb !== 16) begin errors++; $display("FAIL midreset_edges: got %0d required 16", nb); end
    repeat (2 * CD_A + 2) @(negedge clk);
    checks++;
    if (ff_a < 0 || oef_a !== ff_a + 1) begin
      errors++; $display("FAIL midreset_oe_release: got oe fall at %0d required %0d", oef_a, ff_a + 1);
    end
  endtask

  task automatic test_hold_b();
    logic [15:0] w, expw;
    int nb, c, prev_c, n0, wid;
    i_data = 16'($urandom); i_dots = 4'($urandom); i_en_mask = 4'($urandom);
    repeat (4 * PER_B + 10) @(negedge clk);
    qw_b.delete(); qb_b.delete(); qc_b.delete(); qwid_b.delete();
    n0 = -1; prev_c = -1;
    for (int k = 0; k < 6; k++) begin
      pop_b(w, nb, c);
      if (k == 0)
        for (int j = 0; j < 4; j++) if (w[7:0] === (8'h01 << j)) n0 = j;
      expw = model_word(i_data, i_dots, i_en_mask, (n0 < 0 ? 0 : n0 + k) % 4);
      checks++;
      if (n0 < 0 || w !== expw) begin errors++; $display("FAIL hold_word%0d: got %h required %h", k, w, expw); end
      checks++;
      if (nb !== 16) begin errors++; $display("FAIL hold_edges%0d: got %0d required 16", k, nb); end
      if (k > 0) begin
        checks++;
        if (c - prev_c !== PER_B) begin
          errors++; $display("FAIL hold_period%0d: got %0d required %0d", k, c - prev_c, PER_B);
        end
      end
      prev_c = c;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (qwid_b.size() == 0) begin
      errors++; $display("FAIL hold_stcp_width: got no pulse required %0d", CD_B);
    end else begin
      wid = qwid_b.pop_front();
      if (wid !== CD_B) begin errors++; $display("FAIL hold_stcp_width: got %0d required %0d", wid, CD_B); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (ds_err_a != 0) begin errors++; $display("FAIL ds_stable_a: got %0d changes required 0", ds_err_a); end
    checks++; if (bad_shcp_a != 0) begin errors++; $display("FAIL shcp_high_a: got %0d bad pulses required 0", bad_shcp_a); end
    checks++; if (overlap_a != 0) begin errors++; $display("FAIL stcp_shcp_a: got %0d overlaps required 0", overlap_a); end
    checks++; if (oe_rise_a != 0) begin errors++; $display("FAIL oe_permanent_a: got %0d rises required 0", oe_rise_a); end
    checks++; if (ds_err_b != 0) begin errors++; $display("FAIL ds_stable_b: got %0d changes required 0", ds_err_b); end
    checks++; if (bad_shcp_b != 0) begin errors++; $display("FAIL shcp_high_b: got %0d bad pulses required 0", bad_shcp_b); end
    checks++; if (overlap_b != 0) begin errors++; $display("FAIL stcp_shcp_b: got %0d overlaps required 0", overlap_b); end
  endtask

  initial begin
    i_data = 16'h1234; i_dots = 4'h0; i_en_mask = 4'hF;
    cur_d  = 16'h1234; cur_dots = 4'h0; cur_mask = 4'hF;
    test_reset();
    test_first_bit();
    test_fixed_1234();
    test_mask_dots();
    test_midshift_change();
    test_random();
    test_reset_midshift();
    test_hold_b();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
